// File: rtl/mod_reduce_stream.sv
// Streaming modular reducer: folds MSB-first CHUNK_W-bit chunks into a residue
// mod MODULUS with a Horner accumulator and a restoring subtract chain.
module mod_reduce_stream #(
  parameter int MODULUS    = 2011,
  parameter int RES_W      = 11,
  parameter int CHUNK_W    = 6,
  parameter int MAX_CHUNKS = 84,
  parameter int CNT_W      = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [CHUNK_W-1:0] s_data,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [RES_W-1:0]   m_residue,
  output logic [CNT_W-1:0]   m_count,
  output logic               m_err
);
  localparam int TW = RES_W + CHUNK_W;
  localparam logic [TW-1:0] MOD_T = TW'(MODULUS);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t             state_q, state_d;
  logic [RES_W-1:0]   r_q, r_d, res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, mcnt_q, mcnt_d, cnt_inc;
  logic               err_q, err_d, merr_q, merr_d, err_inc;
  logic [TW-1:0]      red;
  logic [RES_W-1:0]   r_next;
  logic               accept;
  logic               unused_red_hi;

  // {r, s_data} < M*2^CHUNK_W, so one conditional subtract per shifted
  // multiple of M leaves an exact residue below M.
  always_comb begin
    red = {r_q, s_data};
    for (int k = CHUNK_W - 1; k >= 0; k--) begin
      if (red >= (MOD_T << k)) red = red - (MOD_T << k);
    end
  end

  assign r_next        = red[RES_W-1:0];
  assign unused_red_hi = |red[TW-1:RES_W];

  assign s_ready   = rst_n & ~clear & (state_q == ACCUM);
  assign m_valid   = (state_q == HOLD);
  assign accept    = s_valid & s_ready;
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign err_inc   = err_q | (cnt_q == CNT_W'(MAX_CHUNKS));
  assign m_residue = res_q;
  assign m_count   = mcnt_q;
  assign m_err     = merr_q;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    res_d   = res_q;
    mcnt_d  = mcnt_q;
    merr_d  = merr_q;
    if (clear) begin
      state_d = ACCUM;
      r_d     = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ACCUM: if (accept) begin
          if (s_last) begin
            res_d   = r_next;
            mcnt_d  = cnt_inc;
            merr_d  = err_inc;
            r_d     = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = HOLD;
          end else begin
            r_d   = r_next;
            cnt_d = cnt_inc;
            err_d = err_inc;
          end
        end
        HOLD: if (m_ready) state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      r_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      res_q   <= '0;
      mcnt_q  <= '0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      res_q   <= res_d;
      mcnt_q  <= mcnt_d;
      merr_q  <= merr_d;
    end
  end
endmodule

// File: tb/tb_mod_reduce_stream.sv
// Directed plus randomized bench for mod_reduce_stream against an arithmetic
// mod model; a second instance covers a small modulus/chunk configuration.
module tb_mod_reduce_stream;
  logic        clk = 1'b0;
  logic        rst_n, clear, s_valid, s_ready, s_last, m_valid, m_ready, m_err;
  logic [5:0]  s_data;
  logic [10:0] m_residue;
  logic [6:0]  m_count;

  logic        b_clear, b_s_valid, b_s_ready, b_s_last, b_m_valid, b_m_ready, b_m_err;
  logic [3:0]  b_s_data;
  logic [2:0]  b_m_residue;
  logic [6:0]  b_m_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] q[$];

  always #5 clk = ~clk;

  mod_reduce_stream dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_residue(m_residue), .m_count(m_count), .m_err(m_err));

  mod_reduce_stream #(.MODULUS(7), .RES_W(3), .CHUNK_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(b_clear), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .s_data(b_s_data), .s_last(b_s_last), .m_valid(b_m_valid), .m_ready(b_m_ready),
    .m_residue(b_m_residue), .m_count(b_m_count), .m_err(b_m_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the chunk is accepted.
  task automatic push(input logic [5:0] d, input logic last);
    logic acc = 1'b0;
    s_valid = 1'b1; s_data = d; s_last = last;
    for (int i = 0; i < 50 && !acc; i++) begin
      #1 acc = s_ready;
      @(posedge clk);
      @(negedge clk);
    end
    if (!acc) chk("accept_timeout", 32'(acc), 1);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic collect(input int exp_res, input int exp_cnt, input int exp_err, input int hold);
    chk("latency_valid", 32'(m_valid), 1);
    chk("residue", 32'(m_residue), exp_res);
    chk("count", 32'(m_count), exp_cnt);
    chk("err", 32'(m_err), exp_err);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(m_valid), 1);
      chk("hold_residue", 32'(m_residue), exp_res);
      chk("hold_sready", 32'(s_ready), 0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("release_valid", 32'(m_valid), 0);
    chk("release_sready", 32'(s_ready), 1);
  endtask

  // Reference: the operand value mod 2011, built as a big number chunk by chunk.
  task automatic run_q(input int hold, input bit gaps);
    int exp_r = 0;
    int n = q.size();
    foreach (q[i]) begin
      exp_r = (exp_r * 64 + int'(q[i])) % 2011;
      if (gaps && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) @(negedge clk);
      push(q[i], i == n - 1);
    end
    collect(exp_r, (n > 127) ? 127 : n, (n > 84) ? 1 : 0, hold);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    b_clear = 1'b0; b_s_valid = 1'b0; b_s_data = '0; b_s_last = 1'b0; b_m_ready = 1'b0;
    #1;
    chk("rst_sready", 32'(s_ready), 0);
    chk("rst_mvalid", 32'(m_valid), 0);
    chk("rst_residue", 32'(m_residue), 0);
    chk("rst_count", 32'(m_count), 0);
    chk("rst_err", 32'(m_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_sready", 32'(s_ready), 1);
    chk("post_rst_mvalid", 32'(m_valid), 0);
    @(negedge clk);

    q = '{6'd63};           run_q(0, 0);
    q = '{6'd31, 6'd27};    run_q(2, 0);
    q = '{6'd31, 6'd26};    run_q(1, 0);
    q = '{6'd63, 6'd63};    run_q(0, 0);

    // overflow: 85 zeros then 1, followed by a clean 2-chunk operand
    q.delete();
    repeat (85) q.push_back(6'd0);
    q.push_back(6'd1);
    run_q(0, 0);
    q = '{6'd2, 6'd3};      run_q(0, 0);

    for (int op = 0; op < 60; op++) begin
      int len = (op % 5 == 0) ? 84 : int'($urandom_range(1, 90));
      q.delete();
      for (int i = 0; i < len; i++) q.push_back(6'($urandom));
      run_q(int'($urandom_range(0, 3)), 1);
    end

    // clear after 10 chunks; the chunk shown during clear must be dropped
    for (int i = 0; i < 10; i++) push(6'($urandom), 1'b0);
    clear = 1'b1; s_valid = 1'b1; s_data = 6'd9; s_last = 1'b1;
    #1 chk("clear_sready", 32'(s_ready), 0);
    @(negedge clk);
    clear = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    chk("clear_no_result", 32'(m_valid), 0);
    q = '{6'd1, 6'd0};      run_q(0, 0);

    // async reset mid-operand
    for (int i = 0; i < 3; i++) push(6'd17, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mid_sready", 32'(s_ready), 0);
    chk("arst_mid_residue", 32'(m_residue), 0);
    chk("arst_mid_count", 32'(m_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    // async reset while holding a result
    push(6'd40, 1'b1);
    chk("pre_arst_hold", 32'(m_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hold_valid", 32'(m_valid), 0);
    chk("arst_hold_residue", 32'(m_residue), 0);
    chk("arst_hold_count", 32'(m_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    q = '{6'd5};            run_q(0, 0);

    // small configuration: 0xFF mod 7 = 3
    b_s_valid = 1'b1; b_s_data = 4'd15; b_s_last = 1'b0;
    #1 chk("b_sready", 32'(b_s_ready), 1);
    @(negedge clk);
    b_s_last = 1'b1;
    @(negedge clk);
    b_s_valid = 1'b0; b_s_last = 1'b0;
    chk("b_valid", 32'(b_m_valid), 1);
    chk("b_residue", 32'(b_m_residue), 3);
    chk("b_count", 32'(b_m_count), 2);
    b_m_ready = 1'b1;
    @(negedge clk);
    b_m_ready = 1'b0;
    chk("b_release", 32'(b_m_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
